// File: rtl/adsr_poly.sv
// Polyphonic ADSR envelope generator: VOICES envelopes share one update datapath, one voice per clock.
// Build option ADSR_RETRIGGER_EN: a gate rising during RELEASE restarts the attack from level 0.
module adsr_poly #(
  parameter int TOTAL_BITS      = 32,
  parameter int FRACTIONAL_BITS = 16,
  parameter int VOICES          = 8,
  localparam int VB             = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [TOTAL_BITS-1:0] a,
  input  logic [TOTAL_BITS-1:0] d,
  input  logic [TOTAL_BITS-1:0] s,
  input  logic [TOTAL_BITS-1:0] r,
  input  logic [VOICES-1:0]     gate,
  output logic [TOTAL_BITS-1:0] out,
  output logic [VB-1:0]         out_voice,
  output logic                  out_valid,
  output logic [VOICES-1:0]     active,
  output logic                  busy,
  output logic                  overrun
);

  localparam int XW = TOTAL_BITS + 1;
  localparam logic signed [XW-1:0] MAX_X = XW'(1) << FRACTIONAL_BITS;
  localparam logic [VB-1:0] LAST_VOICE = VB'(VOICES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DECAY,
    ST_SUSTAIN,
    ST_RELEASE
  } vstate_t;

  vstate_t               state_q [VOICES];
  logic [TOTAL_BITS-1:0] level_q [VOICES];

  logic                  busy_q;
  logic                  overrun_q;
  logic [VB-1:0]         idx_q;
  logic [TOTAL_BITS-1:0] out_q;
  logic [VB-1:0]         out_voice_q;
  logic                  out_valid_q;

  // Rates and sustain are sign-extended by one bit so sums cannot wrap before clamping.
  logic signed [XW-1:0] a_x, d_x, r_x, s_x, s_c;
  logic signed [XW-1:0] lv_cur;
  logic                 gate_cur;
  vstate_t              st_cur;

  vstate_t              st_d;
  logic signed [XW-1:0] lv_d;
  logic signed [XW-1:0] lv_pre;
  logic signed [XW-1:0] step_sum;
  logic signed [XW-1:0] step_dec;
  logic signed [XW-1:0] step_rel;

  assign a_x = signed'({a[TOTAL_BITS-1], a});
  assign d_x = signed'({d[TOTAL_BITS-1], d});
  assign r_x = signed'({r[TOTAL_BITS-1], r});
  assign s_x = signed'({s[TOTAL_BITS-1], s});

  always_comb begin
    s_c = s_x;
    if (s_x < 0) begin
      s_c = '0;
    end else if (s_x > MAX_X) begin
      s_c = MAX_X;
    end
  end

  assign st_cur   = state_q[idx_q];
  assign lv_cur   = signed'({1'b0, level_q[idx_q]});
  assign gate_cur = gate[idx_q];

  // Gate transitions are resolved first so the new state's step applies in this same update.
  always_comb begin
    st_d   = st_cur;
    lv_pre = lv_cur;
    if (gate_cur && (st_cur == ST_IDLE || st_cur == ST_RELEASE)) begin
`ifdef ADSR_RETRIGGER_EN
      if (st_cur == ST_RELEASE) begin
        lv_pre = '0;
      end
`endif
      st_d = ST_ATTACK;
    end else if (!gate_cur &&
                 (st_cur == ST_ATTACK || st_cur == ST_DECAY || st_cur == ST_SUSTAIN)) begin
      st_d = ST_RELEASE;
    end

    step_sum = lv_pre + a_x;
    step_dec = lv_pre - d_x;
    step_rel = lv_pre - r_x;
    lv_d     = lv_pre;

    case (st_d)
      ST_ATTACK: begin
        if (a_x <= 0 || step_sum >= MAX_X) begin
          lv_d = MAX_X;
          st_d = ST_DECAY;
        end else begin
          lv_d = step_sum;
        end
      end
      ST_DECAY: begin
        if (d_x <= 0 || step_dec <= s_c) begin
          lv_d = s_c;
          st_d = ST_SUSTAIN;
        end else begin
          lv_d = step_dec;
        end
      end
      ST_SUSTAIN: lv_d = s_c;
      ST_RELEASE: begin
        if (r_x <= 0 || step_rel <= 0) begin
          lv_d = '0;
          st_d = ST_IDLE;
        end else begin
          lv_d = step_rel;
        end
      end
      default: begin
        lv_d = '0;
        st_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      idx_q       <= '0;
      out_q       <= '0;
      out_voice_q <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        state_q[i] <= ST_IDLE;
        level_q[i] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      if (tick && busy_q) begin
        overrun_q <= 1'b1;
      end
      if (busy_q) begin
        state_q[idx_q] <= st_d;
        level_q[idx_q] <= lv_d[TOTAL_BITS-1:0];
        out_q          <= lv_d[TOTAL_BITS-1:0];
        out_voice_q    <= idx_q;
        out_valid_q    <= 1'b1;
        if (idx_q == LAST_VOICE) begin
          busy_q <= 1'b0;
          idx_q  <= '0;
        end else begin
          idx_q <= idx_q + VB'(1);
        end
      end else if (tick) begin
        busy_q <= 1'b1;
        idx_q  <= '0;
      end
    end
  end

  for (genvar gi = 0; gi < VOICES; gi++) begin : g_active
    assign active[gi] = (state_q[gi] != ST_IDLE);
  end

  assign out       = out_q;
  assign out_voice = out_voice_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_adsr_poly.sv
// Scoreboard bench for adsr_poly (VOICES=4): expected per-voice levels queued per sweep, checked by a monitor.
module tb_adsr_poly;

  localparam int TB = 32;
  localparam int FB = 16;
  localparam int NV = 4;
  localparam int VBW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          tick = 1'b0;
  logic [TB-1:0] a = 32'd655;
  logic [TB-1:0] d = 32'd655;
  logic [TB-1:0] s = 32'd32768;
  logic [TB-1:0] r = 32'd655;
  logic [NV-1:0] gate = '0;
  logic [TB-1:0] out;
  logic [VBW-1:0] out_voice;
  logic          out_valid;
  logic [NV-1:0] active;
  logic          busy;
  logic          overrun;

  int total = 0;
  int bad = 0;
  int out_count = 0;
  int sweep_no = 0;
  int exp_voice[$];
  int exp_level[$];

  adsr_poly #(.TOTAL_BITS(TB), .FRACTIONAL_BITS(FB), .VOICES(NV)) dut (
    .clock(clock), .reset(reset), .tick(tick),
    .a(a), .d(d), .s(s), .r(r), .gate(gate),
    .out(out), .out_voice(out_voice), .out_valid(out_valid),
    .active(active), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every presented output is matched against the oldest queued expectation.
  always @(negedge clock) begin
    if (reset && out_valid) begin
      int ev, el;
      out_count++;
      total++;
      if (exp_level.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got voice=%0d level=%0d expected no output", out_voice, out);
      end else begin
        ev = exp_voice.pop_front();
        el = exp_level.pop_front();
        if (longint'(out_voice) != longint'(ev) || longint'(out) != longint'(el)) begin
          bad++;
          $display("FAIL sweep%0d_output: got voice=%0d level=%0d expected voice=%0d level=%0d",
                   sweep_no, out_voice, out, ev, el);
        end
      end
    end
  end

  task automatic pulse_tick();
    @(posedge clock);
    #1 tick = 1'b1;
    @(posedge clock);
    #1 tick = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL sweep_timeout: got busy=1 expected busy=0 within 20 cycles");
    end
    @(posedge clock);
    #1;
  endtask

  task automatic sweep(input int e0, input int e1, input int e2, input int e3);
    sweep_no++;
    exp_voice.push_back(0); exp_level.push_back(e0);
    exp_voice.push_back(1); exp_level.push_back(e1);
    exp_voice.push_back(2); exp_level.push_back(e2);
    exp_voice.push_back(3); exp_level.push_back(e3);
    pulse_tick();
    wait_idle();
    check("sweep_drained", exp_level.size(), 0);
    $display("sweep %0d gate=%b expect %0d %0d %0d %0d active=%b", sweep_no, gate, e0, e1, e2, e3, active);
  endtask

  initial begin
    int cnt0;
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_out", out, 0);
    check("rst_out_voice", out_voice, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_active", active, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b1;

    // Reset mid-sweep
    gate = 4'b1111;
    exp_voice.push_back(0); exp_level.push_back(655);
    exp_voice.push_back(1); exp_level.push_back(655);
    pulse_tick();
    @(posedge clock);
    @(posedge clock);
    #1;
    check("pre_reset_active", active, 4'b0011);
    reset = 1'b0;
    exp_voice.delete();
    exp_level.delete();
    #1;
    check("midrst_out", out, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_active", active, 0);
    check("midrst_busy", busy, 0);
    @(negedge clock);
    reset = 1'b1;
    gate = '0;
    sweep(0, 0, 0, 0);

    // Full envelope on voice 0
    gate = 4'b0001;
    for (int n = 1; n <= 100; n++) sweep(655 * n, 0, 0, 0);
    sweep(65536, 0, 0, 0);
    for (int n = 102; n <= 151; n++) sweep(65536 - 655 * (n - 101), 0, 0, 0);
    sweep(32768, 0, 0, 0);
    check("sustain_active", active, 4'b0001);
    sweep(32768, 0, 0, 0);
    gate = 4'b0000;
    for (int m = 1; m <= 50; m++) sweep(32768 - 655 * m, 0, 0, 0);
    check("release_still_active", active, 4'b0001);
    sweep(0, 0, 0, 0);
    check("release_idle", active, 0);

    // Independence: voice 1 starts 10 sweeps after voice 2
    gate = 4'b0100;
    for (int n = 1; n <= 10; n++) sweep(0, 0, 655 * n, 0);
    gate = 4'b0110;
    for (int n = 11; n <= 30; n++) sweep(0, 655 * (n - 10), 655 * n, 0);
    check("indep_active", active, 4'b0110);

    // Zero rates and sustain clamping
    a = '0; d = '0; r = '0;
    gate = 4'b0000;
    sweep(0, 0, 0, 0);
    check("zero_r_idle", active, 0);
    gate = 4'b0001;
    sweep(65536, 0, 0, 0);
    sweep(32768, 0, 0, 0);
    s = -32'sd5;
    sweep(0, 0, 0, 0);
    check("neg_sustain_active", active, 4'b0001);
    s = 32'd70000;
    sweep(65536, 0, 0, 0);
    gate = 4'b0000;
    sweep(0, 0, 0, 0);
    check("zero_rate_idle", active, 0);

    // Overrun: second tick two cycles after the first
    check("overrun_before", overrun, 0);
    cnt0 = out_count;
    for (int i = 0; i < NV; i++) begin
      exp_voice.push_back(i);
      exp_level.push_back(0);
    end
    pulse_tick();
    @(posedge clock);
    #1 tick = 1'b1;
    @(posedge clock);
    #1 tick = 1'b0;
    wait_idle();
    repeat (6) @(posedge clock);
    #1;
    check("overrun_outputs", out_count - cnt0, NV);
    check("overrun_set", overrun, 1);
    check("overrun_drained", exp_level.size(), 0);
    sweep(0, 0, 0, 0);
    check("overrun_sticky", overrun, 1);

    // Retrigger from release
    a = 32'd655; d = 32'd655; r = 32'd655; s = 32'd65536;
    gate = 4'b0001;
    for (int n = 1; n <= 100; n++) sweep(655 * n, 0, 0, 0);
    sweep(65536, 0, 0, 0);
    sweep(65536, 0, 0, 0);
    gate = 4'b0000;
    for (int m = 1; m <= 10; m++) sweep(65536 - 655 * m, 0, 0, 0);
    gate = 4'b0001;
`ifdef ADSR_RETRIGGER_EN
    sweep(655, 0, 0, 0);
`else
    sweep(59641, 0, 0, 0);
`endif
    check("retrig_active", active, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got no finish expected finish before 5000000");
    $fatal(1, "global timeout");
  end

endmodule
